// File: rtl/parity_item_gen_if.sv
// Push-side handshake bundle between an item producer and the parity FIFO.
// The master drives valid_o/data_o. The slave answers with grant_i.
// An item transfers on any clock edge where valid_o & grant_i are both high.
interface parity_item_gen_if #(
  parameter int DATA_WIDTH = 17
);
  logic                  valid_o;
  logic                  grant_i;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (output valid_o, output data_o, input grant_i);
  modport slave  (input valid_o, input data_o, output grant_i);
endinterface

// File: rtl/parity_item_gen.sv
// Pseudo-random parity-protected item source. It can corrupt every Nth item.
// Latency: the first item is valid one cycle after an accepted start. After that it sends 1 item/cycle.
// Backpressure: an item is held stable on the bus until grant_i accepts it.
module parity_item_gen #(
  parameter int          DATA_WIDTH = 17,
  parameter logic        PARITY     = 1'b1,
  parameter logic        P_BIT      = 1'b1,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_ACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  parity_item_gen_if.master        bus,
  input  logic                     start,
  input  logic [15:0]              num_items,
  input  logic [7:0]               err_period,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              sent_cnt,
  output logic [15:0]              err_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  state_t      state;
  logic [31:0] lfsr;
  logic [15:0] count;      // latched run length
  logic [7:0]  period;     // latched injection period
  logic [7:0]  phase;      // 1..period position of the presented item
  logic        cur_bad;    // presented item carries inverted parity

  logic [31:0] lfsr_nxt;
  logic [7:0]  phase_nxt;
  logic        bad_nxt;
  logic        last_item;

  // Galois right-shift step; the feedback taps are applied when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // Attach the parity bit (optionally inverted) at the configured position.
  function automatic logic [DATA_WIDTH-1:0] form_item(input logic [DATA_WIDTH-2:0] payload,
                                                      input logic bad);
    logic p;
    p = (^payload) ^ ~PARITY ^ bad;
    return P_BIT ? {payload, p} : {p, payload};
  endfunction

  // Next-item bookkeeping: the injection phase wraps at the latched period. A zero period never corrupts.
  always_comb begin
    lfsr_nxt  = lfsr_step(lfsr);
    phase_nxt = (phase == period) ? 8'd1 : phase + 8'd1;
    bad_nxt   = (period != 8'd0) && (phase_nxt == period);
    last_item = ((sent_cnt + 16'd1) == count);
  end

  // Run control FSM with registered bus, status and counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      count       <= 16'd0;
      period      <= 8'd0;
      phase       <= 8'd0;
      cur_bad     <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_cnt    <= 16'd0;
      err_cnt     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lfsr     <= LFSR_SEED;
            sent_cnt <= 16'd0;
            err_cnt  <= 16'd0;
            if (num_items != 16'd0) begin
              count       <= num_items;
              period      <= err_period;
              phase       <= 8'd1;
              cur_bad     <= (err_period == 8'd1);
              bus.data_o  <= form_item(LFSR_SEED[DATA_WIDTH-2:0], (err_period == 8'd1));
              bus.valid_o <= 1'b1;
              busy        <= 1'b1;
              state       <= SEND;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        SEND: begin
          if (bus.grant_i) begin
            sent_cnt <= sent_cnt + 16'd1;
            if (cur_bad) begin
              err_cnt <= err_cnt + 16'd1;
            end
            lfsr <= lfsr_nxt;
            if (last_item) begin
              bus.valid_o <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= FIN;
            end else begin
              phase      <= phase_nxt;
              cur_bad    <= bad_nxt;
              bus.data_o <= form_item(lfsr_nxt[DATA_WIDTH-2:0], bad_nxt);
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
